muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit that sits beside the ALU in the EX stage and is the driver of the `muldiv_busy` stall request consumed by the hazard detection unit. It accepts one M-extension instruction at a time, runs a 32-step shift-add (multiply) or restoring (divide) loop, and holds the pipeline via `busy_o` until the result is ready. It also absorbs EX-stage flushes so that a mispredicted multiply or divide never writes back.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : EX-stage request/response bundle for the iterative mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [31:0]     instruction_i;
  logic [XLEN-1:0] rs1_val_i;
  logic [XLEN-1:0] rs2_val_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output valid_i, instruction_i, rs1_val_i, rs2_val_i, flush_i,
    input  busy_o, valid_o, result_o, rd_o
  );

  modport slave (
    input  valid_i, instruction_i, rs1_val_i, rs2_val_i, flush_i,
    output busy_o, valid_o, result_o, rd_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit driving the EX-stage stall.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  wire logic       clk_i,
  input  wire logic       rst_ni,
  muldiv_unit_if.slave    bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opb;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_neg_res;
  logic        r_neg_a;
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;

  // ---------------- decode of the offered instruction ----------------
  logic [2:0]  w_funct3;
  logic        w_is_m, w_accept, w_is_div;
  logic        w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special;
  logic [31:0] w_mag_a, w_mag_b, w_special_res;
  logic        w_unused;

  assign w_funct3 = bus.instruction_i[14:12];
  assign w_is_m   = (bus.instruction_i[6:2] == 5'b01100) &&
                    (bus.instruction_i[31:25] == 7'b0000001);
  assign w_accept = bus.valid_i && !bus.flush_i && w_is_m && (r_state != S_CALC);
  assign w_is_div = w_funct3[2];
  assign w_unused = ^{bus.instruction_i[24:15], bus.instruction_i[1:0]};

  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 only for MULH, DIV, REM
  assign w_a_neg = bus.rs1_val_i[31] &&
                   ((w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                    (w_funct3 == 3'b100) || (w_funct3 == 3'b110));
  assign w_b_neg = bus.rs2_val_i[31] &&
                   ((w_funct3 == 3'b001) || (w_funct3 == 3'b100) || (w_funct3 == 3'b110));
  assign w_mag_a = w_a_neg ? (32'd0 - bus.rs1_val_i) : bus.rs1_val_i;
  assign w_mag_b = w_b_neg ? (32'd0 - bus.rs2_val_i) : bus.rs2_val_i;

  assign w_div_zero = w_is_div && (bus.rs2_val_i == 32'd0);
  assign w_ovf      = w_is_div && !w_funct3[0] &&
                      (bus.rs1_val_i == 32'h8000_0000) && (bus.rs2_val_i == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero || w_ovf;

  always_comb begin
    w_special_res = 32'd0;
    if (w_div_zero)
      w_special_res = w_funct3[1] ? bus.rs1_val_i : 32'hFFFF_FFFF;
    else if (w_ovf)
      w_special_res = w_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // ---------------- one iteration of the datapath ----------------
  // r_acc = {high/remainder, low/multiplier-or-quotient}; r_opb = multiplicand/divisor
  logic [32:0] w_mul_sum, w_div_shift, w_div_diff;
  logic [63:0] w_mul_next, w_div_next, w_acc_next, w_prod;
  logic [31:0] w_quo, w_rem, w_final;

  assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_next  = {w_mul_sum, r_acc[31:1]};
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                      : {w_div_diff[31:0],  r_acc[30:0], 1'b1};
  assign w_acc_next  = r_funct3[2] ? w_div_next : w_mul_next;

  assign w_prod = r_neg_res ? (64'd0 - w_acc_next) : w_acc_next;
  assign w_quo  = r_neg_res ? (32'd0 - w_acc_next[31:0]) : w_acc_next[31:0];
  assign w_rem  = r_neg_a   ? (32'd0 - w_acc_next[63:32]) : w_acc_next[63:32];

  always_comb begin
    w_final = w_rem;
    case (r_funct3)
      3'b000:                 w_final = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[63:32];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (bus.flush_i)         w_state_nxt = S_IDLE;
        else if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= 5'd0;
      r_acc     <= 64'd0;
      r_opb     <= 32'd0;
      r_funct3  <= 3'd0;
      r_rd      <= 5'd0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_result  <= 32'd0;
      r_rd_out  <= 5'd0;
    end else if (w_accept) begin
      r_cnt     <= 5'd0;
      r_funct3  <= w_funct3;
      r_rd      <= bus.instruction_i[11:7];
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_a   <= w_a_neg;
      r_acc     <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
      r_opb     <= w_is_div ? w_mag_b : w_mag_a;
      if (w_special) begin
        r_result <= w_special_res;
        r_rd_out <= bus.instruction_i[11:7];
      end
    end else if ((r_state == S_CALC) && !bus.flush_i) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        r_result <= w_final;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.busy_o   = w_accept || (r_state == S_CALC);
  assign bus.valid_o  = (r_state == S_DONE) && !bus.flush_i;
  assign bus.result_o = r_result;
  assign bus.rd_o     = r_rd_out;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic offer(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_i       = 1'b1;
    bus.instruction_i = {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    bus.rs1_val_i     = a;
    bus.rs2_val_i     = b;
  endtask

  // Called mid-cycle of the accept cycle; returns mid-cycle of the completion cycle
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      lat++;
      if (bus.busy_o) busy_cnt++;
    end while (!bus.valid_o && lat < 40);
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_lat);
    int lat, bc;
    @(negedge clk);
    offer(7'b0000001, f3, rd, a, b);
    #1;
    chk({tag, "_busy_acc"}, {31'd0, bus.busy_o}, 32'd1);
    wait_done(lat, bc);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd1);
    chk({tag, "_res"}, bus.result_o, exp);
    chk({tag, "_rd"}, {27'd0, bus.rd_o}, {27'd0, rd});
    chk({tag, "_busy_cyc"}, bc, exp_lat - 1);
  endtask

  initial begin
    int lat, bc, seen;
    n_err = 0;
    n_chk = 0;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.instruction_i = 32'd0;
    bus.rs1_val_i = 32'd0;
    bus.rs2_val_i = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",  {31'd0, bus.busy_o},  32'd0);
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("rst_res",   bus.result_o, 32'd0);
    chk("rst_rd",    {27'd0, bus.rd_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("mul",    3'b000, 5'd3,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run("mulh",   3'b001, 5'd4,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    run("mulhu",  3'b011, 5'd5,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mulhsu", 3'b010, 5'd6,  32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
    run("divu",   3'b101, 5'd7,  32'd100,        32'd7,         32'd14,        33);
    run("remu",   3'b111, 5'd8,  32'd100,        32'd7,         32'd2,         33);
    run("div",    3'b100, 5'd9,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run("rem",    3'b110, 5'd10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run("div0",   3'b100, 5'd11, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run("rem0",   3'b110, 5'd12, 32'd5,          32'd0,         32'd5,         1);
    run("divovf", 3'b100, 5'd13, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("removf", 3'b110, 5'd14, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // flush in CALC cycle 10 of a DIVU
    @(negedge clk);
    offer(7'b0000001, 3'b101, 5'd15, 32'd100, 32'd7);
    repeat (9) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    chk("flush_busy", {31'd0, bus.busy_o}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.valid_o) seen++;
    end
    chk("flush_novalid", seen, 0);
    chk("flush_res_held", bus.result_o, 32'd0);
    run("mul_after_flush", 3'b000, 5'd16, 32'd1000, 32'd3000, 32'd3000000, 33);

    // non-M instruction never stalls
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      offer(7'b0000000, 3'b000, 5'd17, 32'd1, 32'd2);
      #1;
      if (bus.busy_o) seen++;
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (bus.busy_o || bus.valid_o) seen++;
    end
    chk("add_ignored", seen, 0);

    // back-to-back accept in the DONE cycle
    run("b2b_first", 3'b000, 5'd18, 32'd12, 32'd12, 32'd144, 33);
    offer(7'b0000001, 3'b000, 5'd19, 32'hFFFF_FFFF, 32'd5);
    #1;
    chk("b2b_busy_acc", {31'd0, bus.busy_o}, 32'd1);
    wait_done(lat, bc);
    chk("b2b_lat", lat, 33);
    chk("b2b_res", bus.result_o, 32'hFFFF_FFFB);
    chk("b2b_rd", {27'd0, bus.rd_o}, 32'd19);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    offer(7'b0000001, 3'b000, 5'd20, 32'd9, 32'd9);
    repeat (4) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  {31'd0, bus.busy_o},  32'd0);
    chk("arst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("arst_res",   bus.result_o, 32'd0);
    chk("arst_rd",    {27'd0, bus.rd_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.valid_o) seen++;
    end
    chk("arst_novalid", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
